// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: instruction-cache miss refill engine.
// Fetches a full 8-word block, critical word first with wrap-around. The
// critical word is forwarded early as a one-cycle pulse. The assembled
// line is then handed to the cache in a single fill pulse.
module icache_refill_ctrl #(
    parameter int TAG_BITS    = 14,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 5,
    parameter int WORDS       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      miss_valid,
    input  logic [31:0]               miss_addr,
    output logic                      miss_ready,
    output logic                      mem_rd,
    output logic [31:0]               mem_addr,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    output logic                      crit_valid,
    output logic [31:0]               crit_word,
    output logic                      fill_valid,
    output logic [INDEX_BITS-1:0]     fill_index,
    output logic [TAG_BITS-1:0]       fill_tag,
    output logic [WORDS*32-1:0]       fill_data,
    output logic                      busy
);

    localparam int WSEL     = $clog2(WORDS);
    localparam int BLK_BITS = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [BLK_BITS-1:0]     blk;
    logic [WSEL-1:0]         crit;
    logic [WSEL-1:0]         issue_cnt;
    logic [WSEL-1:0]         ret_cnt;
    logic [WSEL-1:0]         slot;
    logic [WORDS-1:0][31:0]  line_buf;
    logic [WORDS-1:0][31:0]  line_nxt;
    logic                    accept;
    logic                    ret_acc;
    logic                    last_ret;
    logic                    last_issue;
    logic [1:0]              unused_addr_bits;

    // Byte-within-word bits carry no meaning for a word-wide refill.
    assign unused_addr_bits = miss_addr[1:0];

    assign miss_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = miss_valid && miss_ready;

    // Returns only count while a refill is in flight; IDLE/DONE drop them.
    assign ret_acc    = mem_rvalid && ((state == ISSUE) || (state == DRAIN));
    assign last_ret   = ret_acc && (ret_cnt == WSEL'(WORDS - 1));
    assign last_issue = (state == ISSUE) && (issue_cnt == WSEL'(WORDS - 1));

    // Returns come back in request order, so slot wraps from the critical word.
    assign slot       = crit + ret_cnt;

    // Next-state decode; the final return may land while still issuing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE: begin
                if (last_ret)        state_nxt = DONE;
                else if (last_issue) state_nxt = DRAIN;
            end
            DRAIN:   if (last_ret) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line buffer with the current return merged in, used for the fill as well.
    always_comb begin
        line_nxt = line_buf;
        if (ret_acc) line_nxt[slot] = mem_rdata;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request side: latch the miss and stream 8 back-to-back word reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk       <= '0;
            crit      <= '0;
            issue_cnt <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else if (accept) begin
            blk       <= miss_addr[31:OFFSET_BITS];
            crit      <= miss_addr[OFFSET_BITS-1:2];
            issue_cnt <= '0;
            mem_rd    <= 1'b1;
            mem_addr  <= {miss_addr[31:2], 2'b00};
        end else if (state == ISSUE) begin
            issue_cnt <= issue_cnt + WSEL'(1);
            mem_rd    <= (state_nxt == ISSUE);
            mem_addr  <= {blk, WSEL'(crit + issue_cnt + WSEL'(1)), 2'b00};
        end else begin
            mem_rd    <= 1'b0;
        end
    end

    // Return side: collect words and forward the first one as the critical word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_cnt    <= '0;
            line_buf   <= '0;
            crit_valid <= 1'b0;
            crit_word  <= '0;
        end else begin
            crit_valid <= ret_acc && (ret_cnt == '0);
            if (ret_acc && (ret_cnt == '0)) crit_word <= mem_rdata;
            if (accept) begin
                ret_cnt  <= '0;
                line_buf <= '0;
            end else if (ret_acc) begin
                ret_cnt  <= ret_cnt + WSEL'(1);
                line_buf <= line_nxt;
            end
        end
    end

    // Fill outputs load on the final return and hold until the next fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_valid <= 1'b0;
            fill_index <= '0;
            fill_tag   <= '0;
            fill_data  <= '0;
        end else begin
            fill_valid <= last_ret;
            if (last_ret) begin
                fill_data  <= line_nxt;
                fill_index <= blk[INDEX_BITS-1:0];
                fill_tag   <= blk[INDEX_BITS +: TAG_BITS];
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized and directed bench with a behavioural
// refill model compared against the DUT on every falling clock edge.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         miss_valid = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         miss_ready, mem_rd, crit_valid, fill_valid, busy;
    logic [31:0]  mem_addr, crit_word;
    logic [7:0]   fill_index;
    logic [13:0]  fill_tag;
    logic [255:0] fill_data;

    icache_refill_ctrl dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
        .miss_ready(miss_ready), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .crit_valid(crit_valid),
        .crit_word(crit_word), .fill_valid(fill_valid), .fill_index(fill_index),
        .fill_tag(fill_tag), .fill_data(fill_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cnt    = 0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E3779B1) ^ s ^ 32'h5A5A0000;
    endfunction

    function automatic logic [255:0] put(input logic [255:0] line, input int w, input logic [31:0] d);
        logic [255:0] r;
        r = line;
        r[w*32 +: 32] = d;
        return r;
    endfunction

    // ---------------- memory: in-order responses, latency + gaps ----------
    int          lat = 2, gap_pct = 0, gap_after = -1, gap_len = 0, hold = 0, ret_seen = 0;
    bit          stray = 1'b0;
    logic [31:0] salt = '0;
    int          q_due[$];
    logic [31:0] q_dat[$];

    always @(negedge clk) begin
        if (mem_rd) begin
            q_due.push_back(cnt + lat);
            q_dat.push_back(memf(mem_addr, salt));
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEADBEEF;
        end else if (hold > 0) begin
            hold--;
        end else if (q_due.size() > 0 && q_due[0] <= cnt && int'($urandom_range(99)) >= gap_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = q_dat.pop_front();
            void'(q_due.pop_front());
            ret_seen++;
            if (ret_seen == gap_after) hold = gap_len;
        end
    end

    // ---------------- behavioural model -----------------------------------
    // phase: 0 idle, 1 refill in progress, 2 fill cycle. m_k counts edges
    // since accept (request k goes out in the k-th cycle after accept).
    int           m_phase = 0, m_k = 0, m_nret = 0;
    logic [26:0]  m_blk = '0;
    logic [2:0]   m_crit = '0;
    logic [255:0] m_line = '0, m_fill_data = '0;
    logic [7:0]   m_fill_index = '0;
    logic [13:0]  m_fill_tag = '0;
    logic         m_crit_pulse = 1'b0;
    logic [31:0]  m_crit_word = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0; m_k <= 0; m_nret <= 0; m_line <= '0;
            m_fill_data <= '0; m_fill_index <= '0; m_fill_tag <= '0;
            m_crit_pulse <= 1'b0; m_crit_word <= '0;
        end else begin
            m_crit_pulse <= 1'b0;
            if (m_phase == 2) begin
                m_phase <= 0;
            end else if (m_phase == 0) begin
                if (miss_valid) begin
                    m_phase <= 1; m_k <= 0; m_nret <= 0; m_line <= '0;
                    m_blk   <= miss_addr[31:5];
                    m_crit  <= miss_addr[4:2];
                end
            end else begin
                m_k <= m_k + 1;
                if (mem_rvalid && m_nret < 8) begin
                    m_line <= put(m_line, (int'(m_crit) + m_nret) % 8, mem_rdata);
                    m_nret <= m_nret + 1;
                    if (m_nret == 0) begin
                        m_crit_pulse <= 1'b1;
                        m_crit_word  <= mem_rdata;
                    end
                    if (m_nret == 7) begin
                        m_phase      <= 2;
                        m_fill_data  <= put(m_line, (int'(m_crit) + m_nret) % 8, mem_rdata);
                        m_fill_index <= m_blk[7:0];
                        m_fill_tag   <= m_blk[21:8];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare -----------------------------------
    always @(negedge clk) begin
        logic       exp_rd;
        logic [2:0] off;
        exp_rd = (m_phase == 1) && (m_k < 8);
        off    = 3'((int'(m_crit) + m_k) % 8);
        chk("miss_ready", 256'(miss_ready), 256'(m_phase == 0));
        chk("busy", 256'(busy), 256'(m_phase != 0));
        chk("mem_rd", 256'(mem_rd), 256'(exp_rd));
        if (exp_rd) chk("mem_addr", 256'(mem_addr), 256'({m_blk, off, 2'b00}));
        chk("crit_valid", 256'(crit_valid), 256'(m_crit_pulse));
        chk("crit_word", 256'(crit_word), 256'(m_crit_word));
        chk("fill_valid", 256'(fill_valid), 256'(m_phase == 2));
        chk("fill_index", 256'(fill_index), 256'(m_fill_index));
        chk("fill_tag", 256'(fill_tag), 256'(m_fill_tag));
        chk("fill_data", fill_data, m_fill_data);
    end

    // ---------------- event monitor (cycle numbers relative to accept) -----
    int          acc_e = 0, acc_prev = 0, n_acc = 0;
    int          crit_rel = 0, fill_rel = 0, crit_n = 0, fill_n = 0;
    logic [31:0] crit_seen = '0;
    logic [31:0] addr_log[$];

    always @(posedge clk) begin
        if (reset && miss_valid && miss_ready) begin
            acc_prev <= acc_e;
            acc_e    <= cnt + 1;
            n_acc    <= n_acc + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_rd) addr_log.push_back(mem_addr);
        if (crit_valid) begin
            crit_n    <= crit_n + 1;
            crit_rel  <= cnt - acc_e + 1;
            crit_seen <= crit_word;
        end
        if (fill_valid) begin
            fill_n   <= fill_n + 1;
            fill_rel <= cnt - acc_e + 1;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic start_miss(input logic [31:0] a);
        miss_valid = 1'b1;
        miss_addr  = a;
        for (int i = 0; i < 100; i++) begin
            if (miss_ready) break;
            @(negedge clk);
        end
        chk("accept_wait", 256'(miss_ready), 256'(1));
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (m_phase == 0 && q_due.size() == 0 && hold == 0) break;
            @(negedge clk);
        end
        chk("idle_wait", 256'(busy), 256'(0));
    endtask

    task automatic run_miss(input logic [31:0] a);
        ret_seen = 0;
        salt     = $urandom;
        addr_log.delete();
        start_miss(a);
        wait_idle();
    endtask

    task automatic chk_line(input logic [31:0] base);
        logic [255:0] fd;
        fd = fill_data;
        for (int w = 0; w < 8; w++)
            chk("line_word", 256'(fd[w*32 +: 32]), 256'(memf(base + 32'(4*w), salt)));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_miss_ready", 256'(miss_ready), 256'(1));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_mem_rd", 256'(mem_rd), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr), 256'(0));
        chk("rst_crit_valid", 256'(crit_valid), 256'(0));
        chk("rst_crit_word", 256'(crit_word), 256'(0));
        chk("rst_fill_valid", 256'(fill_valid), 256'(0));
        chk("rst_fill_index", 256'(fill_index), 256'(0));
        chk("rst_fill_tag", 256'(fill_tag), 256'(0));
        chk("rst_fill_data", fill_data, 256'(0));
    endtask

    // ---------------- main sequence ---------------------------------------
    initial begin
        int           f0, c0, na, low;
        logic [255:0] fd0;
        logic [31:0]  exp_wrap[8];
        exp_wrap = '{32'h1234, 32'h1238, 32'h123C, 32'h1220,
                     32'h1224, 32'h1228, 32'h122C, 32'h1230};

        #1 reset = 1'b0;
        #2 chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // critical-word wrap, L=2
        lat = 2;
        f0  = fill_n;
        run_miss(32'h0000_1234);
        for (int k = 0; k < 8; k++)
            chk("wrap_addr", 256'(addr_log.size() > k ? addr_log[k] : 32'hFFFF_FFFF), 256'(exp_wrap[k]));
        chk("wrap_nreq", 256'(addr_log.size()), 256'(8));
        chk("wrap_crit_cyc", 256'(crit_rel), 256'(4));
        chk("wrap_crit_word", 256'(crit_seen), 256'(memf(32'h1234, salt)));
        chk("wrap_fill_cyc", 256'(fill_rel), 256'(11));
        chk("wrap_fill_index", 256'(fill_index), 256'(8'h91));
        chk("wrap_fill_tag", 256'(fill_tag), 256'(0));
        chk("wrap_fill_count", 256'(fill_n - f0), 256'(1));
        chk_line(32'h0000_1220);

        // aligned block
        lat = 1;
        run_miss(32'h0400_0000);
        chk("align_nreq", 256'(addr_log.size()), 256'(8));
        for (int k = 0; k < 8 && k < addr_log.size(); k++)
            chk("align_addr", 256'(addr_log[k]), 256'(32'h0400_0000 + 32'(4*k)));
        chk("align_fill_tag", 256'(fill_tag), 256'(14'h2000));
        chk("align_fill_index", 256'(fill_index), 256'(0));
        chk_line(32'h0400_0000);

        // gapped returns: 3 idle cycles after the 4th return
        lat = 2; gap_after = 4; gap_len = 3;
        run_miss(32'h0001_5678);
        gap_after = -1;
        chk("gap_fill_cyc", 256'(fill_rel), 256'(14));
        chk("gap_crit_cyc", 256'(crit_rel), 256'(4));
        chk("gap_nreq", 256'(addr_log.size()), 256'(8));
        chk_line(32'h0001_5660);

        // busy back-pressure: miss_valid held with a second address
        lat = 2;
        ret_seen = 0;
        f0  = fill_n;
        na  = n_acc;
        low = 0;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_2000;
        for (int i = 0; i < 50 && !miss_ready; i++) @(negedge clk);
        @(negedge clk);
        miss_addr = 32'h0000_3010;
        for (int i = 0; i < 100; i++) begin
            if (n_acc == na + 2) break;
            if (!miss_ready) low++;
            @(negedge clk);
        end
        miss_valid = 1'b0;
        chk("bp_accepts", 256'(n_acc - na), 256'(2));
        chk("bp_ready_low", 256'(low), 256'(11));
        chk("bp_accept_gap", 256'(acc_e - acc_prev), 256'(12));
        wait_idle();
        chk("bp_fill_count", 256'(fill_n - f0), 256'(2));

        // reset asserted during cycle 5 of a refill
        lat = 2;
        ret_seen = 0;
        addr_log.delete();
        start_miss(32'h0000_4444);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        f0 = fill_n;
        c0 = crit_n;
        repeat (12) @(negedge clk);
        chk("rst_no_fill", 256'(fill_n), 256'(f0));
        chk("rst_no_crit", 256'(crit_n), 256'(c0));
        chk("rst_fill_data_kept", fill_data, 256'(0));
        run_miss(32'h0000_4444);
        chk("rst_next_fill", 256'(fill_n - f0), 256'(1));
        chk("rst_next_index", 256'(fill_index), 256'(8'h22));
        chk_line(32'h0000_4440);

        // stray returns while idle
        @(negedge clk);
        f0  = fill_n;
        c0  = crit_n;
        fd0 = fill_data;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_no_fill", 256'(fill_n), 256'(f0));
        chk("stray_no_crit", 256'(crit_n), 256'(c0));
        chk("stray_fill_data", fill_data, fd0);

        // randomized misses: latency 0..4, random return gaps
        for (int t = 0; t < 25; t++) begin
            lat     = int'($urandom_range(4));
            gap_pct = int'($urandom_range(40));
            repeat ($urandom_range(3)) @(negedge clk);
            f0 = fill_n;
            run_miss($urandom);
            chk("rand_fill_count", 256'(fill_n - f0), 256'(1));
        end
        gap_pct = 0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
